// File: rtl/spi_pkg.sv
// Shared types for the SPI command sequencer: FSM states, error codes and the
// {CPOL,CPHA} mode encoding used by spi_master.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_BUSY,
    ST_DONE
  } spi_seq_st_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_COUNT   = 2'd3;

  typedef enum logic [1:0] {
    SPI_MODE0 = 2'b00,
    SPI_MODE1 = 2'b01,
    SPI_MODE2 = 2'b10,
    SPI_MODE3 = 2'b11
  } spi_mode_t;

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy/free outputs and a
// flush that discards everything stored before the current cycle.
module spi_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic [$clog2(DEPTH):0]     free
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr, rptr;
  logic             empty, full, do_push, do_pop;

  assign count   = wptr - rptr;
  assign free    = PW'(DEPTH) - count;
  assign empty   = (count == '0);
  assign full    = (count == PW'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  // Empty head reads as zero so downstream outputs have a defined reset value.
  assign dout    = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_ONE;
      if (flush)       rptr <= wptr;
      else if (do_pop) rptr <= rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/spi_cmd_seq.sv
// Command sequencer in front of spi_master: buffers write payload, launches one
// transaction per command, collects read bytes and reports done/timeout/errors.
module spi_cmd_seq
  import spi_pkg::*;
#(
  parameter int unsigned MOSI_ADDR_BYTE = 1,
  parameter int unsigned SLAVE_NUM      = 1,
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned TIMEOUT_CYC    = 4096
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_vld,
  output logic                        cmd_rdy,
  input  logic                        cmd_wr,
  input  logic [1:0]                  cmd_mode,
  input  logic [7:0]                  cmd_slv,
  input  logic [8*MOSI_ADDR_BYTE-1:0] cmd_addr,
  input  logic [7:0]                  cmd_num,
  input  logic                        wd_vld,
  output logic                        wd_rdy,
  input  logic [7:0]                  wd_data,
  output logic                        rd_vld,
  input  logic                        rd_rdy,
  output logic [7:0]                  rd_data,
  output logic                        rd_last,
  output logic [7:0]                  r_data,
  output logic [8*MOSI_ADDR_BYTE-1:0] r_address,
  output logic [7:0]                  r_data_num,
  output logic                        r_trg_start,
  output logic [7:0]                  r_slv_sel,
  output logic [7:0]                  r_spi_mode,
  output logic                        r_spi_wr,
  input  logic                        m_en,
  input  logic [7:0]                  m_data,
  input  logic                        m_fnl,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [1:0]                  err_code
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  spi_seq_st_t   state, state_nxt;
  logic [7:0]    byte_cnt, cnt_nxt;
  logic [TW-1:0] to_cnt;
  logic          cmd_acc, cmd_ok;
  logic          ill, fin_err, to_err;
  logic          wf_pop, wf_flush, rf_push, rf_pop;
  logic [AW:0]   wf_count, wf_free, rf_count, rf_free;
  logic [8:0]    rf_dout;

  assign cmd_rdy     = (state == ST_IDLE);
  assign busy        = (state != ST_IDLE);
  assign done        = (state == ST_DONE);
  assign r_trg_start = (state == ST_START);
  assign cmd_acc     = cmd_vld & cmd_rdy;
  assign cmd_ok      = (cmd_num != 8'd0) && (cmd_num <= 8'(FIFO_DEPTH)) &&
                       ({1'b0, cmd_slv} < 9'(SLAVE_NUM));
  assign cnt_nxt     = byte_cnt + {7'd0, m_en};
  assign wd_rdy      = |wf_free;
  assign rd_vld      = |rf_count;
  assign rf_pop      = rd_vld & rd_rdy;
  assign {rd_last, rd_data} = rf_dout;

  spi_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wd_vld),
    .din   (wd_data),
    .pop   (wf_pop),
    .flush (wf_flush),
    .dout  (r_data),
    .count (wf_count),
    .free  (wf_free)
  );

  spi_sync_fifo #(.WIDTH(9), .DEPTH(FIFO_DEPTH)) u_rd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rf_push),
    .din   ({cnt_nxt == r_data_num, m_data}),
    .pop   (rf_pop),
    .flush (1'b0),
    .dout  (rf_dout),
    .count (rf_count),
    .free  (rf_free)
  );

  always_comb begin
    state_nxt = state;
    ill       = 1'b0;
    fin_err   = 1'b0;
    to_err    = 1'b0;
    wf_pop    = 1'b0;
    wf_flush  = 1'b0;
    rf_push   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_acc) begin
          if (cmd_ok) state_nxt = ST_LOAD;
          else        ill       = 1'b1;
        end
      end
      ST_LOAD: begin
        // Read space is reserved up front so the read FIFO cannot overflow.
        if (r_spi_wr ? (8'(wf_count) >= r_data_num) : (8'(rf_free) >= r_data_num))
          state_nxt = ST_START;
      end
      ST_START: state_nxt = ST_BUSY;
      ST_BUSY: begin
        wf_pop  = r_spi_wr & m_en;
        rf_push = ~r_spi_wr & m_en;
        if (m_fnl) begin
          state_nxt = ST_DONE;
          wf_flush  = r_spi_wr;
          fin_err   = (cnt_nxt != r_data_num);
        end else if (to_cnt == TW'(TIMEOUT_CYC - 1)) begin
          state_nxt = ST_IDLE;
          wf_flush  = r_spi_wr;
          to_err    = 1'b1;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      byte_cnt   <= '0;
      to_cnt     <= '0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
      r_address  <= '0;
      r_data_num <= '0;
      r_slv_sel  <= '0;
      r_spi_mode <= '0;
      r_spi_wr   <= 1'b0;
    end else begin
      state <= state_nxt;
      err   <= ill | fin_err | to_err;
      if (ill)          err_code <= ERR_ILLEGAL;
      else if (fin_err) err_code <= ERR_COUNT;
      else if (to_err)  err_code <= ERR_TIMEOUT;
      if (cmd_acc && cmd_ok) begin
        r_address  <= cmd_addr;
        r_data_num <= cmd_num;
        r_slv_sel  <= cmd_slv;
        r_spi_mode <= {6'b0, spi_mode_t'(cmd_mode)};
        r_spi_wr   <= cmd_wr;
      end
      if (state == ST_START) begin
        byte_cnt <= '0;
        to_cnt   <= '0;
      end else if (state == ST_BUSY) begin
        byte_cnt <= cnt_nxt;
        to_cnt   <= to_cnt + TW'(1);
      end
    end
  end

endmodule
